// File: rtl/pmp_csr_file_pkg.sv
// Shared types and constants for the PMP CSR file: privilege levels, pmpcfg layout,
// CSR base addresses and the pmpaddr read-view helper.
package pmp_csr_file_pkg;

    typedef enum logic [1:0] {
        PrivU = 2'b00,
        PrivS = 2'b01,
        PrivM = 2'b11
    } priv_lvl_t;

    typedef enum logic [1:0] {
        ModeOff   = 2'b00,
        ModeTor   = 2'b01,
        ModeNa4   = 2'b10,
        ModeNapot = 2'b11
    } pmp_mode_t;

    typedef struct packed {
        logic      locked;
        logic [1:0] reserved;
        pmp_mode_t addr_mode;
        logic      x;
        logic      w;
        logic      r;
    } pmpcfg_t;

    localparam logic [11:0] CSR_PMPCFG0     = 12'h3A0;
    localparam logic [11:0] CSR_PMPADDR0    = 12'h3B0;
    localparam int unsigned MAX_PMP_ENTRIES = 64;

    // Software-visible pmpaddr: low bits depend on the entry mode when G > 0.
    function automatic logic [63:0] pmpaddr_read(logic [63:0] raw, pmp_mode_t mode,
                                                 int unsigned g);
        logic [63:0] res;
        res = raw;
        for (int unsigned k = 0; k < 64; k++) begin
            if (mode == ModeNapot && g >= 2 && k + 2 <= g) begin
                res[k] = 1'b1;
            end else if ((mode == ModeOff || mode == ModeTor) && g >= 1 && k < g) begin
                res[k] = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pmp_cfg_legalize.sv
// WARL legalization of one pmpcfg byte: returns the value the entry holds after a write
// attempt, plus whether the write is allowed at all.
module pmp_cfg_legalize
    import pmp_csr_file_pkg::*;
#(
    parameter int unsigned PMP_G = 0
) (
    input  pmpcfg_t    old_cfg_i,
    input  logic [7:0] wdata_i,
    output pmpcfg_t    new_cfg_o,
    output logic       we_o
);

    pmpcfg_t wcfg;

    always_comb begin
        wcfg          = pmpcfg_t'(wdata_i);
        wcfg.reserved = 2'b00;
        // W without R is reserved; NA4 does not exist once the grain exceeds 4 bytes.
        we_o = !old_cfg_i.locked && !(wcfg.w && !wcfg.r) &&
               !(wcfg.addr_mode == ModeNa4 && PMP_G >= 1);
        new_cfg_o = we_o ? wcfg : old_cfg_i;
    end

endmodule

// File: rtl/pmp_csr_file.sv
// PMP configuration owner: serves M-mode pmpcfg/pmpaddr CSR accesses through a single
// response buffer, applies lock and WARL rules, and flags state changes to the checkers.
module pmp_csr_file
    import pmp_csr_file_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned NR_ENTRIES = 16,
    parameter int unsigned PLEN       = 56,
    parameter int unsigned PMP_G      = 0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  priv_lvl_t                            priv_lvl_i,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic                                 req_we_i,
    input  logic [11:0]                          req_addr_i,
    input  logic [XLEN-1:0]                      req_wdata_i,
    output logic                                 rsp_valid_o,
    input  logic                                 rsp_ready_i,
    output logic [XLEN-1:0]                      rsp_rdata_o,
    output logic                                 rsp_err_o,
    output pmpcfg_t [NR_ENTRIES-1:0]             conf_o,
    output logic [NR_ENTRIES-1:0][PLEN-3:0]      addr_o,
    output logic                                 flush_o
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned AW = PLEN - 2;

    pmpcfg_t [NR_ENTRIES-1:0]         conf_q, conf_d, conf_leg;
    logic [NR_ENTRIES-1:0][AW-1:0]    addr_q, addr_d;
    logic [NR_ENTRIES-1:0]            cfg_ok, addr_locked;
    logic                             rsp_valid_q, rsp_err_q, flush_q;
    logic [XLEN-1:0]                  rsp_rdata_q, rdata;
    logic                             accept, do_write, cfg_hit, paddr_hit, err;
    logic [3:0]                       cfg_idx;
    logic [5:0]                       paddr_idx;

    assign cfg_hit   = req_addr_i[11:4] == CSR_PMPCFG0[11:4];
    assign paddr_hit = req_addr_i >= CSR_PMPADDR0 &&
                       req_addr_i < CSR_PMPADDR0 + 12'(MAX_PMP_ENTRIES);
    assign cfg_idx   = req_addr_i[3:0];
    assign paddr_idx = 6'(req_addr_i - CSR_PMPADDR0);
    assign err       = priv_lvl_i != PrivM || !(cfg_hit || paddr_hit) ||
                       (XLEN == 64 && cfg_hit && cfg_idx[0]);

    assign req_ready_o = !rsp_valid_q || rsp_ready_i;
    assign accept      = req_valid_i && req_ready_o;
    assign do_write    = accept && req_we_i && !err;

    for (genvar e = 0; e < NR_ENTRIES; e++) begin : g_entry
        pmp_cfg_legalize #(
            .PMP_G (PMP_G)
        ) u_legalize (
            .old_cfg_i (conf_q[e]),
            .wdata_i   (req_wdata_i[8*(e%NB) +: 8]),
            .new_cfg_o (conf_leg[e]),
            .we_o      (cfg_ok[e])
        );
        // A locked TOR entry also freezes the pmpaddr below it, which forms its base.
        if (e + 1 < NR_ENTRIES) begin : g_tor
            assign addr_locked[e] = conf_q[e].locked ||
                                    (conf_q[e+1].locked && conf_q[e+1].addr_mode == ModeTor);
        end else begin : g_last
            assign addr_locked[e] = conf_q[e].locked;
        end
    end

    always_comb begin
        rdata  = '0;
        conf_d = conf_q;
        addr_d = addr_q;
        for (int unsigned e = 0; e < NR_ENTRIES; e++) begin
            // Entry e lives in byte e%NB of pmpcfg index (e/NB)*(NB/4).
            if (cfg_hit && 32'(cfg_idx) == (e / NB) * (NB / 4)) begin
                rdata[8*(e%NB) +: 8] = conf_q[e];
                if (do_write && cfg_ok[e]) begin
                    conf_d[e] = conf_leg[e];
                end
            end
            if (paddr_hit && 32'(paddr_idx) == e) begin
                rdata = XLEN'(pmpaddr_read(64'(addr_q[e]), conf_q[e].addr_mode, PMP_G));
                if (do_write && !addr_locked[e]) begin
                    addr_d[e] = req_wdata_i[AW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            conf_q      <= '0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            flush_q     <= 1'b0;
        end else begin
            conf_q  <= conf_d;
            addr_q  <= addr_d;
            flush_q <= (conf_d != conf_q) || (addr_d != addr_q);
            if (accept) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= err;
                rsp_rdata_q <= err ? '0 : rdata;
            end else if (rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign conf_o      = conf_q;
    assign addr_o      = addr_q;
    assign flush_o     = flush_q;

endmodule

// File: tb/tb_pmp_csr_file.sv
// Self-checking bench for pmp_csr_file: responses go through a scoreboard queue, while each
// scenario task checks entry state, flush and handshake behaviour inline.
module tb_pmp_csr_file;
    import pmp_csr_file_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_n;
    priv_lvl_t                 priv;
    logic                      req_valid, req_we, rsp_ready;
    logic [11:0]               req_addr;
    logic [63:0]               req_wdata;
    logic                      req_ready_o, rsp_valid_o, rsp_err_o, flush_o;
    logic [63:0]               rsp_rdata_o;
    pmpcfg_t [15:0]            conf_o;
    logic [15:0][53:0]         addr_o;

    typedef struct {
        logic [63:0] rd;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    logic post_valid, post_flush;

    always #5 clk = ~clk;

    pmp_csr_file #(
        .XLEN       (64),
        .NR_ENTRIES (16),
        .PLEN       (56),
        .PMP_G      (0)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .priv_lvl_i  (priv),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .conf_o      (conf_o),
        .addr_o      (addr_o),
        .flush_o     (flush_o)
    );

    // Scoreboard: every handshaken response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid_o && rsp_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got rdata=%h err=%b, required no response",
                         rsp_rdata_o, rsp_err_o);
            end else begin
                mon_e = q.pop_front();
                if (rsp_rdata_o !== mon_e.rd || rsp_err_o !== mon_e.err) begin
                    bad++;
                    $display("FAIL rsp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                             rsp_rdata_o, rsp_err_o, mon_e.rd, mon_e.err);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [11:0] a, input logic [63:0] wd,
                         input priv_lvl_t p, input logic [63:0] erd, input logic eerr);
        int n;
        logic ok;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        priv      = p;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 20) begin
            @(negedge clk);
            ok = req_ready_o;
            n++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL req_timeout: addr=%h got ready=0, required ready=1", a);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            q.push_back('{erd, eerr});
            #1 req_valid = 1'b0;
            @(negedge clk);
            post_valid = rsp_valid_o;
            post_flush = flush_o;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (conf_o !== '0 || addr_o !== '0) begin
            bad++;
            $display("FAIL reset_state: got conf=%h addr=%h, required 0", conf_o, addr_o);
        end
        total++;
        if (rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || rsp_rdata_o !== '0 ||
            flush_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b e=%b d=%h f=%b, required all 0",
                     rsp_valid_o, rsp_err_o, rsp_rdata_o, flush_o);
        end
        issue(1'b0, 12'h3A0, 64'h0, PrivM, 64'h0, 1'b0);
        total++;
        if (post_valid !== 1'b1) begin
            bad++;
            $display("FAIL rsp_latency: got rsp_valid=%b one cycle after accept, required 1",
                     post_valid);
        end
        issue(1'b0, 12'h3B0, 64'h0, PrivM, 64'h0, 1'b0);
    endtask

    task automatic test_cfg_write();
        issue(1'b1, 12'h3A0, 64'h1F, PrivM, 64'h0, 1'b0);
        total++;
        if (post_flush !== 1'b1 || conf_o[0] !== 8'h1F) begin
            bad++;
            $display("FAIL cfg_write: got flush=%b conf0=%h, required flush=1 conf0=1f",
                     post_flush, conf_o[0]);
        end
        issue(1'b0, 12'h3A0, 64'h0, PrivM, 64'h1F, 1'b0);
        total++;
        if (post_flush !== 1'b0) begin
            bad++;
            $display("FAIL flush_on_read: got %b, required 0", post_flush);
        end
        issue(1'b1, 12'h3A0, 64'h1F, PrivM, 64'h1F, 1'b0);
        total++;
        if (post_flush !== 1'b0) begin
            bad++;
            $display("FAIL flush_same_value: got %b, required 0", post_flush);
        end
    endtask

    task automatic test_cfg_legal();
        issue(1'b1, 12'h3A0, 64'h021F, PrivM, 64'h1F, 1'b0);
        total++;
        if (conf_o[1] !== 8'h00 || post_flush !== 1'b0) begin
            bad++;
            $display("FAIL cfg_w_only: got conf1=%h flush=%b, required 00 0",
                     conf_o[1], post_flush);
        end
        issue(1'b1, 12'h3A0, 64'h671F, PrivM, 64'h1F, 1'b0);
        total++;
        if (conf_o[1] !== 8'h07 || post_flush !== 1'b1) begin
            bad++;
            $display("FAIL cfg_reserved: got conf1=%h flush=%b, required 07 1",
                     conf_o[1], post_flush);
        end
    endtask

    task automatic test_lock();
        issue(1'b1, 12'h3A0, 64'h89071F, PrivM, 64'h071F, 1'b0);
        total++;
        if (conf_o[2] !== 8'h89) begin
            bad++;
            $display("FAIL lock_set: got conf2=%h, required 89", conf_o[2]);
        end
        issue(1'b1, 12'h3B1, 64'h1234, PrivM, 64'h0, 1'b0);
        total++;
        if (addr_o[1] !== '0 || post_flush !== 1'b0) begin
            bad++;
            $display("FAIL tor_base_lock: got addr1=%h flush=%b, required 0 0",
                     addr_o[1], post_flush);
        end
        issue(1'b1, 12'h3B2, 64'h55, PrivM, 64'h0, 1'b0);
        total++;
        if (addr_o[2] !== '0) begin
            bad++;
            $display("FAIL addr_lock: got addr2=%h, required 0", addr_o[2]);
        end
        issue(1'b1, 12'h3A0, 64'h00071F, PrivM, 64'h89071F, 1'b0);
        total++;
        if (conf_o[2] !== 8'h89 || post_flush !== 1'b0) begin
            bad++;
            $display("FAIL cfg_lock: got conf2=%h flush=%b, required 89 0",
                     conf_o[2], post_flush);
        end
        issue(1'b1, 12'h3B0, 64'hABCD, PrivM, 64'h0, 1'b0);
        total++;
        if (addr_o[0] !== 54'hABCD || post_flush !== 1'b1) begin
            bad++;
            $display("FAIL addr_write: got addr0=%h flush=%b, required abcd 1",
                     addr_o[0], post_flush);
        end
        issue(1'b1, 12'h3B3, 64'hFFFF_FFFF_FFFF_FFFF, PrivM, 64'h0, 1'b0);
        total++;
        if (addr_o[3] !== 54'h3F_FFFF_FFFF_FFFF) begin
            bad++;
            $display("FAIL addr_width: got addr3=%h, required 3fffffffffffff", addr_o[3]);
        end
        issue(1'b0, 12'h3B3, 64'h0, PrivM, 64'h003F_FFFF_FFFF_FFFF, 1'b0);
    endtask

    task automatic test_errors();
        issue(1'b1, 12'h3A1, 64'hFF, PrivM, 64'h0, 1'b1);
        total++;
        if (conf_o[0] !== 8'h1F || post_flush !== 1'b0) begin
            bad++;
            $display("FAIL odd_cfg: got conf0=%h flush=%b, required 1f 0",
                     conf_o[0], post_flush);
        end
        issue(1'b0, 12'h3B0, 64'h0, PrivU, 64'h0, 1'b1);
        issue(1'b1, 12'h3B0, 64'h0, PrivU, 64'h0, 1'b1);
        total++;
        if (addr_o[0] !== 54'hABCD || post_flush !== 1'b0) begin
            bad++;
            $display("FAIL umode_write: got addr0=%h flush=%b, required abcd 0",
                     addr_o[0], post_flush);
        end
        issue(1'b0, 12'h3F0, 64'h0, PrivM, 64'h0, 1'b1);
        issue(1'b0, 12'h39F, 64'h0, PrivM, 64'h0, 1'b1);
        issue(1'b0, 12'h3A2, 64'h0, PrivM, 64'h0, 1'b0);
        issue(1'b1, 12'h3C0, 64'h77, PrivM, 64'h0, 1'b0);
        total++;
        if (post_flush !== 1'b0) begin
            bad++;
            $display("FAIL unimpl_write: got flush=%b, required 0", post_flush);
        end
        issue(1'b0, 12'h3C0, 64'h0, PrivM, 64'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        issue(1'b0, 12'h3A0, 64'h0, PrivM, 64'h89071F, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 12'h3B0;
        priv      = PrivM;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b1 ||
                rsp_rdata_o !== 64'h89071F) begin
                bad++;
                $display("FAIL backpressure: got ready=%b v=%b d=%h, required 0 1 89071f",
                         req_ready_o, rsp_valid_o, rsp_rdata_o);
            end
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL release_ready: got %b, required 1", req_ready_o);
        end
        @(posedge clk);
        q.push_back('{64'hABCD, 1'b0});
        #1 req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_valid: got %b, required 1", rsp_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        issue(1'b0, 12'h3A0, 64'h0, PrivM, 64'h89071F, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (rsp_valid_o !== 1'b0 || conf_o !== '0 || addr_o !== '0) begin
            bad++;
            $display("FAIL reset_mid: got v=%b conf=%h, required 0 0", rsp_valid_o, conf_o);
        end
        issue(1'b1, 12'h3B2, 64'h55, PrivM, 64'h0, 1'b0);
        total++;
        if (addr_o[2] !== 54'h55) begin
            bad++;
            $display("FAIL unlock_by_reset: got addr2=%h, required 55", addr_o[2]);
        end
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        priv      = PrivM;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 12'h0;
        req_wdata = 64'h0;
        rsp_ready = 1'b1;
        test_reset();
        test_cfg_write();
        test_cfg_legal();
        test_lock();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL rsp_missing: got %0d outstanding, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
